cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter TAG_W, default 8, ROB tag width; tag value 0 means "no tag".
REQ-002 SHALL have parameter DATA_W, default 32, result data width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on posedge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port br, input, 1, branch-mispredict flush, synchronous, active-high.
REQ-006 SHALL have port req_valid, input, 4, per-unit result valid; bit0 alu, bit1 mul, bit2 ls, bit3 branch.
REQ-007 SHALL have port req_tag, input, 4*TAG_W, per-unit ROB tag; unit i at [i*TAG_W +: TAG_W].
REQ-008 SHALL have port req_data, input, 4*DATA_W, per-unit result; unit i at [i*DATA_W +: DATA_W].
REQ-009 SHALL have port req_ready, output, 4, per-unit accept; a transfer occurs on a posedge with valid&ready.
REQ-010 SHALL have port cdb_valid, output, 1, registered broadcast valid.
REQ-011 SHALL have port cdb_tag, output, TAG_W, registered broadcast tag.
REQ-012 SHALL have port cdb_data, output, DATA_W, registered broadcast data.
REQ-013 SHALL have port cdb_src, output, 2, index of the unit broadcast.
REQ-014 SHALL have port err_zero_tag, output, 1, sticky flag: a tag-0 request was accepted.

Function
REQ-015 SHALL hold one slot per unit (valid bit, tag, data); slot i loads on req_valid[i]&req_ready[i].
REQ-016 SHALL drive req_ready[i] = !slot_valid[i] | grant[i]; no combinational path from any req_* input to req_ready.
REQ-017 SHALL compute grant combinationally from slot_valid only: first valid slot scanning rr_ptr, rr_ptr+1, ... mod 4; at most one grant bit set.
REQ-018 SHALL, on a grant to slot g, register cdb_valid=1, cdb_tag/cdb_data=slot g contents, cdb_src=g at the same edge, and clear slot g unless reloaded that edge.
REQ-019 SHALL set cdb_valid=0 on any cycle with no valid slot; cdb_tag/cdb_data/cdb_src then hold their previous values.
REQ-020 SHALL advance rr_ptr to (g+1) mod 4 after each grant; rr_ptr SHALL hold when nothing is granted.
REQ-021 SHALL provide latency: accept at edge N -> cdb_valid high after edge N+1 at the earliest.
REQ-022 SHALL sustain one broadcast per cycle aggregate and one per cycle per unit when only that unit requests (grant and reload on the same edge).
REQ-023 SHALL guarantee a pending slot is broadcast within 4 cycles of becoming valid.
REQ-024 SHALL accept a request with tag 0, discard it (no slot load, no broadcast), and set err_zero_tag, which stays set until rst.
REQ-025 SHALL, on br=1, clear all slot valids and cdb_valid at that edge, ignore requests presented that cycle, force req_ready=0 that cycle, and leave rr_ptr unchanged.
REQ-026 SHALL give rst priority over br when both are asserted.

Reset
REQ-027 SHALL, on rst=1 at posedge, set cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, all slot valids=0, rr_ptr=0, err_zero_tag=0.
REQ-028 SHALL force req_ready=0 while rst=1; req_ready SHALL be 4'b1111 in the first cycle after reset release.
REQ-029 SHALL, on rst asserted mid-operation, drop pending slots without broadcasting them.

Verification
REQ-030 SHALL check single request: after reset, alu valid, tag 0x05, data 0x1234 for 1 cycle -> next cycle cdb_valid=1, tag 0x05, data 0x1234, src 0; following cycle cdb_valid=0.
REQ-031 SHALL check contention: all 4 valid in one cycle with tags 1,2,3,4, rr_ptr=0 -> broadcasts over 4 consecutive cycles in src order 0,1,2,3; rr_ptr ends at 0.
REQ-032 SHALL check fairness: mul (tag 0x10) and ls (tag 0x20) held valid continuously -> cdb_src alternates 1,2,1,2; neither unit idles more than 1 cycle.
REQ-033 SHALL check flush: ls slot and branch slot pending, br pulsed -> no broadcast of either tag, cdb_valid=0 the next cycle, req_ready=4'b1111 the cycle after.
REQ-034 SHALL check tag-0 handling: alu valid, tag 0, data 0xDEAD -> no cdb_valid, err_zero_tag=1 and held until rst.
REQ-035 SHALL check back-to-back: alu valid for 3 cycles, tags 7,8,9, only requester -> cdb_valid high 3 consecutive cycles, tags 7,8,9, req_ready[0] constantly 1.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one result slot per execution unit, round-robin
// selection of a pending slot, registered broadcast on the CDB.
module cdb_arbiter #(
  parameter int TAG_W  = 8,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  br,
  input  logic [3:0]            req_valid,
  input  logic [4*TAG_W-1:0]    req_tag,
  input  logic [4*DATA_W-1:0]   req_data,
  output logic [3:0]            req_ready,
  output logic                  cdb_valid,
  output logic [TAG_W-1:0]      cdb_tag,
  output logic [DATA_W-1:0]     cdb_data,
  output logic [1:0]            cdb_src,
  output logic                  err_zero_tag
);

  logic [3:0]        slot_vld_p0;
  logic [TAG_W-1:0]  slot_tag_p0  [4];
  logic [DATA_W-1:0] slot_data_p0 [4];
  logic [1:0]        rr_ptr;

  logic [TAG_W-1:0]  tag_in  [4];
  logic [DATA_W-1:0] data_in [4];
  logic [3:0]        grant;
  logic [3:0]        accept;
  logic [3:0]        load;
  logic [3:0]        zero_hit;
  logic              gnt_any;
  logic [1:0]        gnt_idx;

  // Returns {any, index} of the first set bit scanning from ptr upward, wrapping.
  function automatic logic [2:0] rr_pick(input logic [3:0] v, input logic [1:0] ptr);
    logic [1:0] idx;
    logic       found;
    logic [1:0] sel;
    found = 1'b0;
    sel   = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && v[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    return {found, sel};
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      tag_in[i]  = req_tag[i*TAG_W +: TAG_W];
      data_in[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  assign {gnt_any, gnt_idx} = rr_pick(slot_vld_p0, rr_ptr);
  assign grant = gnt_any ? (4'b0001 << gnt_idx) : 4'b0000;

  // Ready depends only on slot state and grant, never on the request inputs.
  assign req_ready = (rst || br) ? 4'b0000 : (~slot_vld_p0 | grant);
  assign accept    = req_valid & req_ready;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      zero_hit[i] = accept[i] && (tag_in[i] == '0);
      load[i]     = accept[i] && (tag_in[i] != '0);
    end
  end

  // Stage p0: slot control state
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_vld_p0  <= '0;
      rr_ptr       <= '0;
      err_zero_tag <= 1'b0;
    end else if (br) begin
      slot_vld_p0  <= '0;
    end else begin
      slot_vld_p0  <= load | (slot_vld_p0 & ~grant);
      if (gnt_any) rr_ptr <= gnt_idx + 2'd1;
      if (|zero_hit) err_zero_tag <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (load[i]) begin
        slot_tag_p0[i]  <= tag_in[i];
        slot_data_p0[i] <= data_in[i];
      end
    end
  end

  // Stage p1: registered CDB broadcast
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
    end else if (br) begin
      cdb_valid <= 1'b0;
    end else begin
      cdb_valid <= gnt_any;
      if (gnt_any) begin
        cdb_tag  <= slot_tag_p0[gnt_idx];
        cdb_data <= slot_data_p0[gnt_idx];
        cdb_src  <= gnt_idx;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single, contention, fairness,
// flush, tag-0 handling, back-to-back and mid-operation reset.
module tb_cdb_arbiter;
  localparam int TAG_W  = 8;
  localparam int DATA_W = 32;

  logic                clk = 1'b0;
  logic                rst;
  logic                br;
  logic [3:0]          req_valid;
  logic [4*TAG_W-1:0]  req_tag;
  logic [4*DATA_W-1:0] req_data;
  logic [3:0]          req_ready;
  logic                cdb_valid;
  logic [TAG_W-1:0]    cdb_tag;
  logic [DATA_W-1:0]   cdb_data;
  logic [1:0]          cdb_src;
  logic                err_zero_tag;

  int n_checks = 0;
  int n_pass   = 0;

  cdb_arbiter #(.TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .br(br), .req_valid(req_valid), .req_tag(req_tag),
    .req_data(req_data), .req_ready(req_ready), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_src(cdb_src),
    .err_zero_tag(err_zero_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    req_valid[i] = 1'b1;
    req_tag[i*TAG_W +: TAG_W]    = t;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; br = 1'b0; req_valid = '0; req_tag = '0; req_data = '0;
    tick();
    tick();
    chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("rst_cdb_tag",   64'(cdb_tag),   64'd0);
    chk("rst_cdb_data",  64'(cdb_data),  64'd0);
    chk("rst_cdb_src",   64'(cdb_src),   64'd0);
    chk("rst_err",       64'(err_zero_tag), 64'd0);
    chk("rst_ready_low", 64'(req_ready), 64'h0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 64'(req_ready), 64'hF);

    // single request from alu
    set_req(0, 8'h05, 32'h1234);
    tick();
    req_valid = '0;
    chk("single_lat_valid", 64'(cdb_valid), 64'd0);
    tick();
    chk("single_valid", 64'(cdb_valid), 64'd1);
    chk("single_tag",   64'(cdb_tag),   64'h05);
    chk("single_data",  64'(cdb_data),  64'h1234);
    chk("single_src",   64'(cdb_src),   64'd0);
    tick();
    chk("single_idle",  64'(cdb_valid), 64'd0);
    chk("single_hold_tag", 64'(cdb_tag), 64'h05);

    // contention from rr_ptr=0
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, TAG_W'(i + 1), DATA_W'(32'hA0 + i));
    tick();
    req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("cont_valid", 64'(cdb_valid), 64'd1);
      chk("cont_src",   64'(cdb_src),   64'(i));
      chk("cont_tag",   64'(cdb_tag),   64'(i + 1));
      chk("cont_data",  64'(cdb_data),  64'(32'hA0 + i));
    end
    tick();
    chk("cont_drained", 64'(cdb_valid), 64'd0);
    // rr_ptr back at 0: units 3 and 0 together must serve 0 first
    set_req(3, 8'h33, 32'h3);
    set_req(0, 8'h30, 32'h0);
    tick();
    req_valid = '0;
    tick();
    chk("rr_wrap_src0", 64'(cdb_src), 64'd0);
    tick();
    chk("rr_wrap_src3", 64'(cdb_src), 64'd3);
    tick();

    // fairness: mul and ls held valid, rr_ptr now 0
    set_req(1, 8'h10, 32'h100);
    set_req(2, 8'h20, 32'h200);
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("fair_valid", 64'(cdb_valid), 64'd1);
      chk("fair_src",   64'(cdb_src),   (k % 2 == 0) ? 64'd1 : 64'd2);
      chk("fair_tag",   64'(cdb_tag),   (k % 2 == 0) ? 64'h10 : 64'h20);
    end
    req_valid = '0;
    tick();
    tick();
    tick();
    chk("fair_drained", 64'(cdb_valid), 64'd0);

    // flush with ls and branch pending
    set_req(2, 8'h33, 32'h333);
    set_req(3, 8'h44, 32'h444);
    tick();
    req_valid = '0;
    br = 1'b1;
    #1;
    chk("flush_ready_low", 64'(req_ready), 64'h0);
    tick();
    br = 1'b0;
    chk("flush_cdb_valid", 64'(cdb_valid), 64'd0);
    #1;
    chk("flush_ready_full", 64'(req_ready), 64'hF);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("flush_no_bcast", 64'(cdb_valid), 64'd0);
    end

    // tag 0 discarded, error sticky
    set_req(0, 8'h00, 32'hDEAD);
    tick();
    req_valid = '0;
    chk("zero_err", 64'(err_zero_tag), 64'd1);
    tick();
    chk("zero_no_bcast", 64'(cdb_valid), 64'd0);
    tick();
    tick();
    chk("zero_err_held", 64'(err_zero_tag), 64'd1);

    // back-to-back alu
    set_req(0, 8'h07, 32'h7);
    #1;
    chk("b2b_ready0", 64'(req_ready[0]), 64'd1);
    tick();
    set_req(0, 8'h08, 32'h8);
    #1;
    chk("b2b_ready1", 64'(req_ready[0]), 64'd1);
    tick();
    chk("b2b_tag7", 64'(cdb_tag), 64'h07);
    chk("b2b_v7", 64'(cdb_valid), 64'd1);
    set_req(0, 8'h09, 32'h9);
    #1;
    chk("b2b_ready2", 64'(req_ready[0]), 64'd1);
    tick();
    req_valid = '0;
    chk("b2b_tag8", 64'(cdb_tag), 64'h08);
    chk("b2b_v8", 64'(cdb_valid), 64'd1);
    tick();
    chk("b2b_tag9", 64'(cdb_tag), 64'h09);
    chk("b2b_v9", 64'(cdb_valid), 64'd1);
    tick();
    chk("b2b_end", 64'(cdb_valid), 64'd0);

    // reset mid-operation drops pending slots and clears the error flag
    set_req(1, 8'h55, 32'h55);
    set_req(2, 8'h66, 32'h66);
    tick();
    req_valid = '0;
    tick();
    chk("mid_first_bcast", 64'(cdb_valid), 64'd1);
    rst = 1'b1;
    br  = 1'b1;
    tick();
    br  = 1'b0;
    chk("mid_rst_valid", 64'(cdb_valid), 64'd0);
    chk("mid_rst_tag",   64'(cdb_tag),   64'd0);
    chk("mid_rst_err",   64'(err_zero_tag), 64'd0);
    rst = 1'b0;
    tick();
    chk("mid_no_bcast", 64'(cdb_valid), 64'd0);
    tick();
    chk("mid_no_bcast2", 64'(cdb_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
